// File: rtl/hub75_fb_if.sv
// Framebuffer read-port bundle: two requester ports plus the shared framebuffer side.
// The slave modport is the arbiter's view; master is everything around it (requesters and the framebuffer).
interface hub75_fb_if;
  logic        req_0;
  logic [13:0] addr_0;
  logic        lock_0;
  logic        gnt_0;
  logic        rvalid_0;

  logic        req_1;
  logic [13:0] addr_1;
  logic        gnt_1;
  logic        rvalid_1;

  logic [19:0] rdata;

  logic [13:0] fb_raddr;
  logic        fb_re;
  logic [19:0] fb_rdata;

  modport slave (
    input  req_0, addr_0, lock_0, req_1, addr_1, fb_rdata,
    output gnt_0, rvalid_0, gnt_1, rvalid_1, rdata, fb_raddr, fb_re
  );

  modport master (
    output req_0, addr_0, lock_0, req_1, addr_1, fb_rdata,
    input  gnt_0, rvalid_0, gnt_1, rvalid_1, rdata, fb_raddr, fb_re
  );
endinterface

// File: rtl/hub75_fb_arbiter.sv
// Shares the framebuffer read port between display fetch (port 0, priority) and an auxiliary
// reader (port 1), with a starvation guard for port 1 and a tag pipeline that steers returned words.
module hub75_fb_arbiter #(
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 63
) (
  input logic       sys_clk,
  input logic       rst_n,
  hub75_fb_if.slave bus
);

  localparam logic       GUARD_EN = (MAX_WAIT != 0);
  localparam logic [7:0] WAIT_TGT = 8'(MAX_WAIT);
  // With the guard disabled the counter only runs up to its ceiling and parks there.
  localparam logic [7:0] WAIT_LIM = GUARD_EN ? WAIT_TGT : 8'hFF;

  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [RD_LAT-1:0] tag_port_q, tag_port_d;

  logic        force_1;
  logic        gnt_0;
  logic        gnt_1;
  logic        fb_re;
  logic [13:0] fb_raddr;

  // Grants are gated by rst_n so nothing reaches the framebuffer while in reset.
  always_comb begin
    force_1  = bus.req_1 & ~bus.lock_0 & GUARD_EN & (wait_cnt_q == WAIT_TGT);
    gnt_1    = rst_n & bus.req_1 & (~bus.req_0 | force_1);
    gnt_0    = rst_n & bus.req_0 & ~gnt_1;
    fb_re    = gnt_0 | gnt_1;
    fb_raddr = 14'd0;
    if (gnt_1) begin
      fb_raddr = bus.addr_1;
    end else if (gnt_0) begin
      fb_raddr = bus.addr_0;
    end
  end

  // Holding at the limit while lock_0 is high keeps the forced slot pending until the lock drops.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (~bus.req_1 | gnt_1) begin
      wait_cnt_d = 8'd0;
    end else if (wait_cnt_q != WAIT_LIM) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_comb begin
    tag_vld_d     = '0;
    tag_port_d    = '0;
    tag_vld_d[0]  = fb_re;
    tag_port_d[0] = gnt_1;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_vld_d[i]  = tag_vld_q[i-1];
      tag_port_d[i] = tag_port_q[i-1];
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= 8'd0;
      tag_vld_q  <= '0;
      tag_port_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      tag_vld_q  <= tag_vld_d;
      tag_port_q <= tag_port_d;
    end
  end

  assign bus.gnt_0    = gnt_0;
  assign bus.gnt_1    = gnt_1;
  assign bus.fb_re    = fb_re;
  assign bus.fb_raddr = fb_raddr;
  assign bus.rvalid_0 = tag_vld_q[RD_LAT-1] & ~tag_port_q[RD_LAT-1];
  assign bus.rvalid_1 = tag_vld_q[RD_LAT-1] &  tag_port_q[RD_LAT-1];
  assign bus.rdata    = bus.fb_rdata;

endmodule

// File: tb/tb_hub75_fb_arbiter.sv
// Bench for hub75_fb_arbiter: three instances (RD_LAT/MAX_WAIT = 1/3, 3/0, 2/63) share one stimulus
// stream and are each checked every cycle against a grant/return model built from the arbitration rules.
module tb_hub75_fb_arbiter;

  localparam int N = 3;

  function automatic int lat_of(input int g);
    case (g)
      0:       return 1;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int mw_of(input int g);
    case (g)
      0:       return 3;
      1:       return 0;
      default: return 63;
    endcase
  endfunction

  function automatic logic [19:0] fb_word(input logic [13:0] a);
    return {a[5:0], a} ^ 20'h5A5A5;
  endfunction

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic        rst_n;
  logic        req_0, req_1, lock_0;
  logic [13:0] addr_0, addr_1;

  logic        obs_gnt0  [N];
  logic        obs_gnt1  [N];
  logic        obs_re    [N];
  logic        obs_rv0   [N];
  logic        obs_rv1   [N];
  logic [13:0] obs_raddr [N];
  logic [19:0] obs_rdata [N];

  for (genvar g = 0; g < N; g++) begin : inst
    localparam int L = lat_of(g);
    hub75_fb_if bus ();
    logic [14:0] fb_pipe [4];

    assign bus.req_0  = req_0;
    assign bus.addr_0 = addr_0;
    assign bus.lock_0 = lock_0;
    assign bus.req_1  = req_1;
    assign bus.addr_1 = addr_1;

    // Framebuffer stand-in: word for the address read L cycles ago, filler otherwise.
    always @(posedge sys_clk) begin
      fb_pipe[0] <= {bus.fb_re, bus.fb_raddr};
      for (int k = 1; k < 4; k++) fb_pipe[k] <= fb_pipe[k-1];
    end
    assign bus.fb_rdata = fb_pipe[L-1][14] ? fb_word(fb_pipe[L-1][13:0]) : 20'hBAD00;

    hub75_fb_arbiter #(.RD_LAT(L), .MAX_WAIT(mw_of(g))) dut (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .bus     (bus)
    );

    assign obs_gnt0[g]  = bus.gnt_0;
    assign obs_gnt1[g]  = bus.gnt_1;
    assign obs_re[g]    = bus.fb_re;
    assign obs_rv0[g]   = bus.rvalid_0;
    assign obs_rv1[g]   = bus.rvalid_1;
    assign obs_raddr[g] = bus.fb_raddr;
    assign obs_rdata[g] = bus.rdata;
  end

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int          streak [N];
  bit          hv [N][8];
  bit          hp [N][8];
  logic [13:0] ha [N][8];

  logic        snap_gnt0  [N];
  logic        snap_gnt1  [N];
  logic        snap_rv1   [N];
  logic [19:0] snap_rdata [N];
  int          cnt_gnt1   [N];
  int          cnt_rv     [N];
  int          cnt_rv1    [N];

  task automatic chk(input string tag, input int i, input logic [19:0] obs, input logic [19:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s inst=%0d cyc=%0d observed=%0h expected=%0h", tag, i, cyc, obs, exp);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < N; i++) begin
      cnt_gnt1[i] = 0;
      cnt_rv[i]   = 0;
      cnt_rv1[i]  = 0;
    end
  endtask

  // One cycle: inputs were set after the falling edge; compare, advance the model, wait for the next falling edge.
  task automatic step();
    bit          frc, e0, e1, ev;
    int          lat, mw, sl;
    logic [13:0] ea;
    #1;
    for (int i = 0; i < N; i++) begin
      lat = lat_of(i);
      mw  = mw_of(i);
      frc = req_1 && !lock_0 && (mw != 0) && (streak[i] >= mw);
      e1  = rst_n && req_1 && (!req_0 || frc);
      e0  = rst_n && req_0 && !e1;
      ea  = e1 ? addr_1 : (e0 ? addr_0 : 14'd0);
      sl  = (cyc + 8 - lat) % 8;
      ev  = rst_n && hv[i][sl];

      chk("gnt_0",    i, 20'(obs_gnt0[i]),  20'(e0));
      chk("gnt_1",    i, 20'(obs_gnt1[i]),  20'(e1));
      chk("fb_re",    i, 20'(obs_re[i]),    20'(e0 | e1));
      chk("fb_raddr", i, 20'(obs_raddr[i]), 20'(ea));
      chk("rvalid_0", i, 20'(obs_rv0[i]),   20'(ev && !hp[i][sl]));
      chk("rvalid_1", i, 20'(obs_rv1[i]),   20'(ev && hp[i][sl]));
      if (ev) chk("rdata", i, obs_rdata[i], fb_word(ha[i][sl]));

      snap_gnt0[i]  = obs_gnt0[i];
      snap_gnt1[i]  = obs_gnt1[i];
      snap_rv1[i]   = obs_rv1[i];
      snap_rdata[i] = obs_rdata[i];
      if (obs_gnt1[i]) cnt_gnt1[i]++;
      if (obs_rv0[i] || obs_rv1[i]) cnt_rv[i]++;
      if (obs_rv1[i]) cnt_rv1[i]++;

      hv[i][cyc % 8] = e0 || e1;
      hp[i][cyc % 8] = e1;
      ha[i][cyc % 8] = ea;
      if (!rst_n) begin
        for (int k = 0; k < 8; k++) hv[i][k] = 1'b0;
      end
      streak[i] = (!rst_n || !req_1 || e1) ? 0 : streak[i] + 1;
    end
    cyc++;
    @(negedge sys_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b1;
    req_0  = 1'b0;
    req_1  = 1'b0;
    lock_0 = 1'b0;
    addr_0 = 14'd0;
    addr_1 = 14'd0;
    for (int i = 0; i < N; i++) begin
      streak[i] = 0;
      for (int k = 0; k < 8; k++) hv[i][k] = 1'b0;
    end
    clr();
    #2 rst_n = 1'b0;
    @(negedge sys_clk);
    repeat (3) step();

    // Port 0 streaming addresses 0..15.
    rst_n = 1'b1;
    clr();
    for (int a = 0; a < 16; a++) begin
      req_0  = 1'b1;
      addr_0 = 14'(a);
      step();
    end
    req_0 = 1'b0;
    repeat (4) step();
    for (int i = 0; i < N; i++) chk("p0_only_rvalid_1_count", i, 20'(cnt_rv1[i]), 20'd0);
    chk("p0_only_rvalid_0_count", 0, 20'(cnt_rv[0]), 20'd16);

    // Short contention burst.
    clr();
    req_0  = 1'b1;
    req_1  = 1'b1;
    addr_1 = 14'h1234;
    repeat (40) begin
      addr_0 = 14'($urandom);
      step();
    end
    chk("contend_gnt_1_count", 0, 20'(cnt_gnt1[0]), 20'd10);
    chk("contend_gnt_1_count", 1, 20'(cnt_gnt1[1]), 20'd0);
    chk("contend_gnt_1_count", 2, 20'(cnt_gnt1[2]), 20'd0);
    req_0 = 1'b0;
    req_1 = 1'b0;
    repeat (4) step();

    // Lock held for 10 cycles under contention, then released.
    clr();
    req_0  = 1'b1;
    req_1  = 1'b1;
    lock_0 = 1'b1;
    addr_1 = 14'h0777;
    repeat (10) begin
      addr_0 = 14'($urandom);
      step();
    end
    for (int i = 0; i < N; i++) chk("lock_gnt_1_count", i, 20'(cnt_gnt1[i]), 20'd0);
    lock_0 = 1'b0;
    step();
    chk("unlock_gnt_1", 0, 20'(snap_gnt1[0]), 20'd1);
    step();
    chk("unlock_then_gnt_0", 0, 20'(snap_gnt0[0]), 20'd1);
    req_0 = 1'b0;
    req_1 = 1'b0;
    repeat (4) step();

    // Port 1 alone.
    req_1  = 1'b1;
    addr_1 = 14'h2A5A;
    step();
    for (int i = 0; i < N; i++) chk("p1_alone_gnt_1", i, 20'(snap_gnt1[i]), 20'd1);
    req_1 = 1'b0;
    repeat (3) step();
    chk("p1_alone_rvalid_1", 1, 20'(snap_rv1[1]), 20'd1);
    chk("p1_alone_rdata", 1, snap_rdata[1], fb_word(14'h2A5A));
    repeat (2) step();

    // Long contention: 300 cycles.
    clr();
    req_0  = 1'b1;
    req_1  = 1'b1;
    addr_1 = 14'h3001;
    repeat (300) begin
      addr_0 = 14'($urandom);
      step();
    end
    chk("long_gnt_1_count", 0, 20'(cnt_gnt1[0]), 20'd75);
    chk("long_gnt_1_count", 1, 20'(cnt_gnt1[1]), 20'd0);
    chk("long_gnt_1_count", 2, 20'(cnt_gnt1[2]), 20'd4);
    req_0 = 1'b0;
    req_1 = 1'b0;
    repeat (4) step();

    // Reset with two reads in flight.
    req_0  = 1'b1;
    addr_0 = 14'h0100;
    step();
    addr_0 = 14'h0101;
    step();
    clr();
    req_1 = 1'b1;
    rst_n = 1'b0;
    repeat (3) step();
    for (int i = 0; i < N; i++) chk("reset_rvalid_count", i, 20'(cnt_rv[i]), 20'd0);
    for (int i = 0; i < N; i++) chk("reset_gnt_1_count", i, 20'(cnt_gnt1[i]), 20'd0);
    rst_n  = 1'b1;
    req_0  = 1'b0;
    addr_1 = 14'h0ABC;
    step();
    for (int i = 0; i < N; i++) chk("post_reset_gnt_1", i, 20'(snap_gnt1[i]), 20'd1);
    clr();
    req_0 = 1'b1;
    repeat (4) step();
    chk("post_reset_forced_slot", 0, 20'(snap_gnt1[0]), 20'd1);
    chk("post_reset_gnt_1_count", 0, 20'(cnt_gnt1[0]), 20'd1);

    // Randomized traffic with occasional lock and reset pulses.
    repeat (500) begin
      rst_n  = ($urandom_range(0, 99) != 0);
      req_0  = ($urandom_range(0, 3) != 0);
      req_1  = ($urandom_range(0, 2) != 0);
      lock_0 = ($urandom_range(0, 5) == 0);
      addr_0 = 14'($urandom);
      addr_1 = 14'($urandom);
      step();
    end
    rst_n  = 1'b1;
    req_0  = 1'b0;
    req_1  = 1'b0;
    lock_0 = 1'b0;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
